// File: rtl/imem_interface.sv
// imem_interface: instruction-memory front end for the fetch stage.
// Serves the fetch pc from a small tagged buffer; on a miss it stalls
// fetch and pulls the word from a variable-latency memory over a
// valid/ready request and valid response handshake.
// Optional feature macro: IMEM_PREFETCH_EN (two entries, LRU bit,
// sequential prefetch of pc+1). Undefined: one entry, demand fetch only.

`ifndef ADDRESS_SIZE
  `define ADDRESS_SIZE 32
`endif
`ifndef INSTRUCTION_SIZE
  `define INSTRUCTION_SIZE 32
`endif
`ifndef NOP_INST
  `define NOP_INST 32'h00000013
`endif

module imem_interface #(
  parameter int ADDRESS_WIDTH = `ADDRESS_SIZE,
  parameter int DATA_WIDTH    = `INSTRUCTION_SIZE
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  logic                     halt,
  output logic [DATA_WIDTH-1:0]    instruction,
  output logic                     stall,
  output logic                     mem_req_valid,
  output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
  input  logic                     mem_req_ready,
  input  logic                     mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]    mem_resp_data,
  output logic [15:0]              miss_count
);

`ifdef IMEM_PREFETCH_EN
  localparam int ENTRIES = 2;
`else
  localparam int ENTRIES = 1;
`endif

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                     count_miss;
  logic                     fill;
  logic                     fill_idx;
  logic                     hit;

  logic                     entry_valid [ENTRIES];
  logic [ADDRESS_WIDTH-1:0] entry_tag   [ENTRIES];
  logic [DATA_WIDTH-1:0]    entry_data  [ENTRIES];

`ifdef IMEM_PREFETCH_EN
  logic                     hit_idx;
  logic                     lru_q;
  logic                     victim_q, victim_d;
  logic [ADDRESS_WIDTH-1:0] next_pc;
  logic                     next_present;

  assign next_pc  = pc + ADDRESS_WIDTH'(1);
  assign fill_idx = victim_q;
`else
  assign fill_idx = 1'b0;
`endif

  // Buffer lookup: hit detection and instruction select, purely from buffer and pc.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hit         = 1'b0;
    instruction = `NOP_INST;
    for (int i = 0; i < ENTRIES; i++) begin
      if (entry_valid[i] && entry_tag[i] == pc) begin
        hit         = 1'b1;
        instruction = entry_data[i];
      end
    end
  end

  assign stall = !hit;

`ifdef IMEM_PREFETCH_EN
  // Which entry pc hit in, and whether pc+1 is already buffered.
  always_comb begin
    hit_idx      = 1'b0;
    next_present = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (entry_valid[i] && entry_tag[i] == pc)      hit_idx      = 1'(i);
      if (entry_valid[i] && entry_tag[i] == next_pc) next_present = 1'b1;
    end
  end
`endif

  // Next-state logic: start demand (or prefetch) in IDLE, handshake in REQUEST, fill in WAIT.
  // Stall is derived from the buffer alone, so demand and prefetch requests
  // need no distinction once issued.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    count_miss = 1'b0;
    fill       = 1'b0;
`ifdef IMEM_PREFETCH_EN
    victim_d   = victim_q;
`endif
    case (state_q)
      IDLE: begin
        if (!halt) begin
          if (!hit) begin
            req_addr_d = pc;
            count_miss = 1'b1;
            state_d    = REQUEST;
`ifdef IMEM_PREFETCH_EN
            victim_d   = lru_q;
          end else if (!next_present) begin
            req_addr_d = next_pc;
            victim_d   = ~hit_idx;
            state_d    = REQUEST;
`endif
          end
        end
      end
      REQUEST: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, request address and victim registers.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
`ifdef IMEM_PREFETCH_EN
      victim_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
`ifdef IMEM_PREFETCH_EN
      victim_q   <= victim_d;
`endif
    end
  end

  assign mem_req_valid = (state_q == REQUEST);
  assign mem_req_addr  = req_addr_q;

  // Entry valid bits: cleared by reset, set when a response fills the victim.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) entry_valid[i] <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (fill && fill_idx == 1'(i)) entry_valid[i] <= 1'b1;
      end
    end
  end

  // Entry tag and data storage, written on fill.
  always_ff @(posedge clock) begin
    // NOTE: tag/data storage is not reset; the valid bit alone gates its use.
    for (int i = 0; i < ENTRIES; i++) begin
      if (fill && fill_idx == 1'(i)) begin
        entry_tag[i]  <= req_addr_q;
        entry_data[i] <= mem_resp_data;
      end
    end
  end

  // Saturating demand-miss counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      miss_count <= '0;
    end else if (count_miss && miss_count != 16'hFFFF) begin
      miss_count <= miss_count + 16'd1;
    end
  end

`ifdef IMEM_PREFETCH_EN
  // LRU bit points away from the entry most recently filled, else most recently hit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lru_q <= 1'b0;
    end else if (fill) begin
      lru_q <= ~victim_q;
    end else if (hit) begin
      lru_q <= ~hit_idx;
    end
  end
`endif

endmodule

// File: doc/imem_interface.md
# imem_interface

Instruction-memory front end sitting directly upstream of the fetch stage. It receives the fetch `pc` and returns the matching instruction from a small tagged buffer. On a miss it raises `stall` toward fetch and retrieves the word from a variable-latency instruction memory over a valid/ready request and valid response handshake. Optional sequential prefetch hides memory latency on straight-line code.

## Interface
- `ADDRESS_WIDTH`, default `` `ADDRESS_SIZE ``: pc and memory address width.
- `DATA_WIDTH`, default `` `INSTRUCTION_SIZE ``: instruction width.
- `clock` in, 1: rising-edge clock.
- `reset` in, 1: asynchronous, active-low.
- `pc` in, ADDRESS_WIDTH: fetch address, from the fetch stage.
- `halt` in, 1: core halted; no new memory requests start.
- `instruction` out, DATA_WIDTH: instruction at `pc`; valid when `stall`=0.
- `stall` out, 1: `pc` not present in the buffer; fetch must hold.
- `mem_req_valid` out, 1: request valid.
- `mem_req_addr` out, ADDRESS_WIDTH: request address.
- `mem_req_ready` in, 1: memory accepts the request.
- `mem_resp_valid` in, 1: response data valid.
- `mem_resp_data` in, DATA_WIDTH: response word.
- `miss_count` out, 16: saturating count of demand misses.

## Operation
- The buffer holds entries of {valid, tag[ADDRESS_WIDTH], data}: 1 entry without prefetch, 2 with prefetch.
- Hit: any valid entry with tag == `pc`. `instruction` and `stall` are combinational from the buffer and `pc`.
  - On hit: `stall`=0 and `instruction`=entry data.
  - On miss: `stall`=1 and `instruction`=`` `NOP_INST ``.
- FSM states: IDLE, REQUEST, WAIT.
  - IDLE, miss, !halt: latch `req_addr`=`pc`, mark the request demand, increment `miss_count` (saturate at 16'hFFFF), go to REQUEST.
  - IDLE, miss, halt: stay in IDLE.
  - REQUEST: `mem_req_valid`=1 and `mem_req_addr`=`req_addr`. Go to WAIT on `mem_req_ready`; otherwise hold with valid and address stable.
  - WAIT: on `mem_resp_valid`, write {1, `req_addr`, `mem_resp_data`} into the victim entry, then go to IDLE.
  - `mem_resp_valid` outside WAIT is ignored.
- Only one request is outstanding at a time. Memory returns responses in order, exactly one per accepted request.
- A response whose tag no longer matches `pc` is still written; it is harmless.
- Address arithmetic is modulo 2^ADDRESS_WIDTH: the prefetch of all-ones wraps to 0.

## Timing
- Reset values: FSM=IDLE, all entries invalid, `mem_req_valid`=0, `mem_req_addr`=0, `miss_count`=0, `stall`=1 (combinational miss), `instruction`=`` `NOP_INST ``, LRU bit=0.
- Minimum miss penalty, with ready=1 and the response one cycle after acceptance:
  - cycle 0: miss detected.
  - cycle 1: REQUEST, handshake completes.
  - cycle 2: WAIT, response captured.
  - cycle 3: hit, `stall`=0.
  - That is 3 stall cycles.
- `halt` never aborts an outstanding request. That request completes and fills the buffer.
- Reset mid-transaction returns to the reset state immediately. The memory shares `reset`, so no stale response survives.

## Configuration
- `IMEM_PREFETCH_EN` defined: 2 entries plus an LRU bit.
  - The LRU bit points at the entry not most recently hit or filled.
  - Demand victim = LRU entry.
  - In IDLE, if `pc` hits in entry k, !halt, and `pc`+1 is not in either entry: issue a prefetch for `pc`+1 into entry 1-k.
  - A prefetch does not assert `stall` and does not count in `miss_count`.
  - If `pc` misses while a prefetch is outstanding, `stall` stays 1 until the prefetch fills. The FSM then re-evaluates from IDLE, so `pc`==prefetch address becomes a hit; otherwise a demand request follows.
- `IMEM_PREFETCH_EN` undefined: one entry, always the victim. No prefetch logic and no LRU bit.

## Test plan
- Reset, `pc`=0, ready=1, response latency 1 with data 0x1234 -> `stall`=1 for 3 cycles, then `instruction`=0x1234, `miss_count`=1.
- `mem_req_ready` held low for 5 cycles in REQUEST -> `mem_req_valid`=1 and `mem_req_addr` stable throughout; `stall` stays 1; no state advance.
- `halt`=1 while `pc`=0x10 misses -> no request issued, `stall`=1. Drop `halt` -> request issued for 0x10.
- With `IMEM_PREFETCH_EN`: after the fill of 0x20, a request for 0x21 follows immediately with `stall`=0. `pc` advancing to 0x21 then hits with zero stall, and `miss_count` is unchanged.
- With `IMEM_PREFETCH_EN`: prefetch of all-ones address -> `mem_req_addr`=0 (wrap). Also: `pc` jumps to 0x40 during an outstanding prefetch -> stall until the prefetch fills, then a demand request for 0x40.
- Assert `reset` while in WAIT -> next cycle: all entries invalid, `mem_req_valid`=0, `miss_count`=0.
